bram_sp_requester: RTL

Initiator-side controller for a single-port, byte-masked block RAM with 1-cycle registered read latency. It accepts valid/ready read and write requests from a client and drives the BRAM command port, at most one command per cycle. It captures read data into a credit-managed response FIFO. After reset it zero-fills the whole BRAM before accepting traffic, and sits between a client engine and its private BRAM scratchpad.

---
 rtl/bram_req_pkg.sv | 22 ++
 rtl/bram_rsp_fifo.sv | 83 ++++++++
 rtl/bram_sp_requester.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bram_req_pkg.sv
// Shared types and sizing helpers for the single-port BRAM requester.
package bram_req_pkg;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    // Credit counter must represent 0..depth inclusive.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Response FIFO for read data; depth need not be a power of two.
module bram_rsp_fifo
    import bram_req_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RSP_DEPTH  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DATA_WIDTH-1:0] head_o
);

    localparam int unsigned PW = ptr_width(RSP_DEPTH);
    localparam int unsigned CW = credit_width(RSP_DEPTH);
    localparam logic [PW-1:0] LastPtr = PW'(RSP_DEPTH - 1);
    localparam logic [CW-1:0] FullCnt = CW'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
    logic [PW-1:0]         wptr_q, wptr_d;
    logic [PW-1:0]         rptr_q, rptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (cnt_q == FullCnt);
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = ptr_inc(wptr_q);
        end
        if (do_pop) begin
            rptr_d = ptr_inc(rptr_q);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && push_i) begin
            assert (!full_o)
            else $error("bram_rsp_fifo: push into full FIFO");
        end
    end

endmodule

// File: rtl/bram_sp_requester.sv
// Client-side controller for a byte-masked single-port BRAM: zero-fill after reset, then
// valid/ready reads and writes with credit-managed read responses.
// Define BRAM_REQ_WRITE_ACK_EN to make writes consume credit and return a zero response.
module bram_sp_requester
    import bram_req_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH = 32,
    parameter  int unsigned BRAM_DEPTH = 128,
    parameter  int unsigned RSP_DEPTH  = 3,
    localparam int unsigned ADDR_WIDTH = addr_width(BRAM_DEPTH),
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_data_i,
    input  logic [MASK_WIDTH-1:0] req_mask_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_data_o,
    output logic                  init_done_o,
    output logic                  bram_cmd_en_o,
    output logic                  bram_wr_en_o,
    output logic [ADDR_WIDTH-1:0] bram_addr_o,
    output logic [DATA_WIDTH-1:0] bram_data_o,
    output logic [MASK_WIDTH-1:0] bram_mask_o,
    input  logic [DATA_WIDTH-1:0] bram_data_i
);

    localparam int unsigned CW = credit_width(RSP_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(BRAM_DEPTH - 1);
    localparam logic [CW-1:0]         CreditMax = CW'(RSP_DEPTH);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] fill_q, fill_d;
    logic [CW-1:0]         credit_q, credit_d;
    logic                  pend_q, pend_d;
    logic                  has_credit;
    logic                  handshake;
    logic                  consume;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_wdata;

    assign has_credit = (credit_q != '0);
    assign init_done_o = (state_q == StRun);

    // Ready is a function of registered state and req_write_i only.
    always_comb begin
        req_ready_o = 1'b0;
        if (rst_ni && state_q == StRun) begin
`ifdef BRAM_REQ_WRITE_ACK_EN
            req_ready_o = has_credit;
`else
            req_ready_o = req_write_i | has_credit;
`endif
        end
    end

    assign handshake = req_valid_i & req_ready_o;

`ifdef BRAM_REQ_WRITE_ACK_EN
    logic pend_wr_q;

    assign consume    = handshake;
    assign pend_d     = handshake;
    assign fifo_wdata = pend_wr_q ? '0 : bram_data_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_wr_q <= 1'b0;
        end else begin
            pend_wr_q <= handshake & req_write_i;
        end
    end
`else
    assign consume    = handshake & ~req_write_i;
    assign pend_d     = consume;
    assign fifo_wdata = bram_data_i;
`endif

    always_comb begin
        state_d       = state_q;
        fill_d        = fill_q;
        bram_cmd_en_o = 1'b0;
        bram_wr_en_o  = 1'b0;
        bram_addr_o   = '0;
        bram_data_o   = '0;
        bram_mask_o   = '0;
        case (state_q)
            StInit: begin
                bram_cmd_en_o = 1'b1;
                bram_wr_en_o  = 1'b1;
                bram_addr_o   = fill_q;
                bram_mask_o   = '1;
                if (fill_q == LastAddr) begin
                    state_d = StRun;
                end else begin
                    fill_d = fill_q + 1'b1;
                end
            end
            StRun: begin
                if (handshake) begin
                    bram_cmd_en_o = 1'b1;
                    bram_wr_en_o  = req_write_i;
                    bram_addr_o   = req_addr_i;
                    if (req_write_i) begin
                        bram_data_o = req_data_i;
                        bram_mask_o = req_mask_i;
                    end
                end
            end
            default: state_d = StInit;
        endcase
        // No command may reach the BRAM while reset is held.
        if (!rst_ni) begin
            bram_cmd_en_o = 1'b0;
        end
    end

    assign fifo_pop = rsp_valid_o & rsp_ready_i;

    always_comb begin
        credit_d = credit_q;
        if (consume && !fifo_pop) begin
            credit_d = credit_q - CW'(1);
        end else if (fifo_pop && !consume) begin
            credit_d = credit_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StInit;
            fill_q   <= '0;
            credit_q <= CreditMax;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            credit_q <= credit_d;
            pend_q   <= pend_d;
        end
    end

    bram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .push_i      (pend_q),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .head_o      (rsp_data_o)
    );

    assign rsp_valid_o = ~fifo_empty;

    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (credit_q <= CreditMax)
            else $error("bram_sp_requester: credit above RSP_DEPTH");
            assert (!(pend_q && fifo_full && !fifo_pop))
            else $error("bram_sp_requester: response with no FIFO space");
        end
    end

endmodule
